// File: rtl/timer_apb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : timer_apb_arbiter
//  Description : Round-robin arbiter giving two req/ack requesters access to
//                a single APB timer slave. Runs SETUP/ACCESS toward the slave,
//                returns read data and error status, and aborts transfers
//                whose slave holds PREADY low for TIMEOUT wait cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_apb_arbiter #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT        = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    // requester side
    input  logic [1:0]                req_i,
    input  logic [1:0]                we_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr0_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr1_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata0_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata1_i,
    output logic [1:0]                ack_o,
    output logic                      err_o,
    output logic [APB_DATA_WIDTH-1:0] rdata0_o,
    output logic [APB_DATA_WIDTH-1:0] rdata1_o,
    // APB master side
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [APB_DATA_WIDTH-1:0] PWDATA,
    input  logic [APB_DATA_WIDTH-1:0] PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    // Wait counter only needs to hold TIMEOUT itself; keep at least one bit
    // so the logic stays well formed when the watchdog is disabled.
    localparam int c_cnt_width = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_width-1:0] c_cnt_limit = c_cnt_width'(TIMEOUT);
    localparam logic [c_cnt_width-1:0] c_cnt_one   = c_cnt_width'(1);
    localparam logic [c_cnt_width-1:0] c_cnt_max   = {c_cnt_width{1'b1}};
    localparam bit                     c_wdog_en   = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Registered state and outputs
    state_t                    r_state;
    logic                      r_last_grant;
    logic                      r_grant;
    logic [c_cnt_width-1:0]    r_wait_cnt;
    logic [1:0]                r_ack;
    logic                      r_err;
    logic [APB_DATA_WIDTH-1:0] r_rdata0;
    logic [APB_DATA_WIDTH-1:0] r_rdata1;
    logic                      r_psel;
    logic                      r_penable;
    logic                      r_pwrite;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [APB_DATA_WIDTH-1:0] r_pwdata;

    // Next-state values
    state_t                    w_state_nxt;
    logic                      w_last_grant_nxt;
    logic                      w_grant_nxt;
    logic [c_cnt_width-1:0]    w_wait_cnt_nxt;
    logic [1:0]                w_ack_nxt;
    logic                      w_err_nxt;
    logic [APB_DATA_WIDTH-1:0] w_rdata0_nxt;
    logic [APB_DATA_WIDTH-1:0] w_rdata1_nxt;
    logic                      w_psel_nxt;
    logic                      w_penable_nxt;
    logic                      w_pwrite_nxt;
    logic [APB_ADDR_WIDTH-1:0] w_paddr_nxt;
    logic [APB_DATA_WIDTH-1:0] w_pwdata_nxt;

    // Candidate winner: a lone requester wins, a tie goes to the one that
    // was not served last.
    logic w_pick;
    assign w_pick = (req_i == 2'b11) ? ~r_last_grant : req_i[1];

    // Next-state, bus and completion logic for the IDLE/SETUP/ACCESS sequence
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_grant_nxt      = r_grant;
        w_wait_cnt_nxt   = r_wait_cnt;
        w_ack_nxt        = 2'b00;
        w_err_nxt        = 1'b0;
        w_rdata0_nxt     = r_rdata0;
        w_rdata1_nxt     = r_rdata1;
        w_psel_nxt       = r_psel;
        w_penable_nxt    = r_penable;
        w_pwrite_nxt     = r_pwrite;
        w_paddr_nxt      = r_paddr;
        w_pwdata_nxt     = r_pwdata;

        case (r_state)
            IDLE: begin
                // During an ack cycle the served requester is still dropping
                // req, so arbitration waits one cycle.
                if ((r_ack == 2'b00) && (req_i != 2'b00)) begin
                    w_grant_nxt      = w_pick;
                    w_last_grant_nxt = w_pick;
                    w_pwrite_nxt     = we_i[w_pick];
                    w_paddr_nxt      = w_pick ? addr1_i  : addr0_i;
                    w_pwdata_nxt     = w_pick ? wdata1_i : wdata0_i;
                    w_psel_nxt       = 1'b1;
                    w_penable_nxt    = 1'b0;
                    w_state_nxt      = SETUP;
                end
            end

            SETUP: begin
                w_penable_nxt = 1'b1;
                w_state_nxt   = ACCESS;
            end

            ACCESS: begin
                if (PREADY) begin
                    w_ack_nxt[r_grant] = 1'b1;
                    w_err_nxt          = PSLVERR;
                    if (!r_pwrite) begin
                        if (r_grant) begin
                            w_rdata1_nxt = PRDATA;
                        end else begin
                            w_rdata0_nxt = PRDATA;
                        end
                    end
                    w_psel_nxt     = 1'b0;
                    w_penable_nxt  = 1'b0;
                    w_pwrite_nxt   = 1'b0;
                    w_paddr_nxt    = '0;
                    w_pwdata_nxt   = '0;
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = IDLE;
                end else if (c_wdog_en && (r_wait_cnt == c_cnt_limit)) begin
                    // Watchdog abort: report an error, leave read data alone.
                    w_ack_nxt[r_grant] = 1'b1;
                    w_err_nxt          = 1'b1;
                    w_psel_nxt         = 1'b0;
                    w_penable_nxt      = 1'b0;
                    w_pwrite_nxt       = 1'b0;
                    w_paddr_nxt        = '0;
                    w_pwdata_nxt       = '0;
                    w_wait_cnt_nxt     = '0;
                    w_state_nxt        = IDLE;
                end else if (r_wait_cnt != c_cnt_max) begin
                    w_wait_cnt_nxt = r_wait_cnt + c_cnt_one;
                end
            end

            default: begin
                w_psel_nxt     = 1'b0;
                w_penable_nxt  = 1'b0;
                w_pwrite_nxt   = 1'b0;
                w_paddr_nxt    = '0;
                w_pwdata_nxt   = '0;
                w_wait_cnt_nxt = '0;
                w_state_nxt    = IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves requester 0 winning the first tie
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_wait_cnt   <= '0;
            r_ack        <= 2'b00;
            r_err        <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_grant      <= w_grant_nxt;
            r_wait_cnt   <= w_wait_cnt_nxt;
            r_ack        <= w_ack_nxt;
            r_err        <= w_err_nxt;
            r_rdata0     <= w_rdata0_nxt;
            r_rdata1     <= w_rdata1_nxt;
            r_psel       <= w_psel_nxt;
            r_penable    <= w_penable_nxt;
            r_pwrite     <= w_pwrite_nxt;
            r_paddr      <= w_paddr_nxt;
            r_pwdata     <= w_pwdata_nxt;
        end
    end

    assign ack_o    = r_ack;
    assign err_o    = r_err;
    assign rdata0_o = r_rdata0;
    assign rdata1_o = r_rdata1;
    assign PSEL     = r_psel;
    assign PENABLE  = r_penable;
    assign PWRITE   = r_pwrite;
    assign PADDR    = r_paddr;
    assign PWDATA   = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_timer_apb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_apb_arbiter
//  Description : Directed bench for timer_apb_arbiter: single read, round-robin
//                contention, wait states with slave error, watchdog abort and
//                reset in the middle of a transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_apb_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          HCLK;
    logic          HRESET;
    logic [1:0]    req_i;
    logic [1:0]    we_i;
    logic [AW-1:0] addr0_i;
    logic [AW-1:0] addr1_i;
    logic [DW-1:0] wdata0_i;
    logic [DW-1:0] wdata1_i;
    logic [1:0]    ack_o;
    logic          err_o;
    logic [DW-1:0] rdata0_o;
    logic [DW-1:0] rdata1_o;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    int n_vec;
    int n_err;

    timer_apb_arbiter #(
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .TIMEOUT        (TO)
    ) u_dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .req_i    (req_i),
        .we_i     (we_i),
        .addr0_i  (addr0_i),
        .addr1_i  (addr1_i),
        .wdata0_i (wdata0_i),
        .wdata1_i (wdata1_i),
        .ack_o    (ack_o),
        .err_o    (err_o),
        .rdata0_o (rdata0_o),
        .rdata1_o (rdata1_o),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    // Free-running clock, 10 ns period
    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog got=stalled exp=finished");
        $fatal(1, "simulation time limit reached");
    end

    // Compare one observed value against its expected value
    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Directed sequence; cycle numbers in comments count edges after the grant edge
    initial begin
        n_vec    = 0;
        n_err    = 0;
        HRESET   = 1'b1;
        req_i    = 2'b00;
        we_i     = 2'b00;
        addr0_i  = '0;
        addr1_i  = '0;
        wdata0_i = '0;
        wdata1_i = '0;
        PRDATA   = '0;
        PREADY   = 1'b1;
        PSLVERR  = 1'b0;
        tick();
        tick();
        tick();

        // Reset state
        chk_eq("rst_psel",    32'(PSEL),    32'h0);
        chk_eq("rst_penable", 32'(PENABLE), 32'h0);
        chk_eq("rst_paddr",   32'(PADDR),   32'h0);
        chk_eq("rst_ack",     32'(ack_o),   32'h0);
        chk_eq("rst_rdata0",  rdata0_o,     32'h0);

        // Single read by requester 0; req dropped early, command changed
        HRESET  = 1'b0;
        req_i   = 2'b01;
        we_i    = 2'b00;
        addr0_i = 12'h004;
        PRDATA  = 32'h1234_5678;
        PREADY  = 1'b1;
        tick();                                   // cycle 1: SETUP
        chk_eq("rd_setup_psel",    32'(PSEL),    32'h1);
        chk_eq("rd_setup_penable", 32'(PENABLE), 32'h0);
        chk_eq("rd_setup_paddr",   32'(PADDR),   32'h004);
        req_i   = 2'b00;
        addr0_i = 12'hFFF;
        tick();                                   // cycle 2: ACCESS
        chk_eq("rd_acc_psel",    32'(PSEL),    32'h1);
        chk_eq("rd_acc_penable", 32'(PENABLE), 32'h1);
        chk_eq("rd_acc_paddr",   32'(PADDR),   32'h004);
        tick();                                   // cycle 3: ack
        chk_eq("rd_ack",    32'(ack_o), 32'h1);
        chk_eq("rd_err",    32'(err_o), 32'h0);
        chk_eq("rd_rdata0", rdata0_o,   32'h1234_5678);
        chk_eq("rd_psel0",  32'(PSEL),  32'h0);
        chk_eq("rd_paddr0", 32'(PADDR), 32'h0);
        tick();                                   // cycle 4: idle
        chk_eq("rd_ack_pulse", 32'(ack_o), 32'h0);

        // Wait states: requester 1 read, 3 low ACCESS cycles then PSLVERR
        req_i   = 2'b10;
        we_i    = 2'b00;
        addr1_i = 12'h0A8;
        PREADY  = 1'b0;
        PRDATA  = 32'hDEAD_BEEF;
        tick();                                   // cycle 1: SETUP
        chk_eq("ws_setup_paddr", 32'(PADDR), 32'h0A8);
        for (int c = 2; c <= 4; c++) begin
            tick();                               // cycles 2..4: waiting
            chk_eq("ws_wait_paddr", 32'(PADDR),   32'h0A8);
            chk_eq("ws_wait_pen",   32'(PENABLE), 32'h1);
            chk_eq("ws_wait_ack",   32'(ack_o),   32'h0);
        end
        tick();                                   // cycle 5: ready
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        chk_eq("ws_final_paddr", 32'(PADDR), 32'h0A8);
        tick();                                   // cycle 6: ack
        chk_eq("ws_ack",    32'(ack_o), 32'h2);
        chk_eq("ws_err",    32'(err_o), 32'h1);
        chk_eq("ws_rdata1", rdata1_o,   32'hDEAD_BEEF);
        chk_eq("ws_rdata0", rdata0_o,   32'h1234_5678);
        req_i   = 2'b00;
        PSLVERR = 1'b0;
        tick();                                   // idle

        // Contention: both write continuously, last grant was 1
        req_i    = 2'b11;
        we_i     = 2'b11;
        addr0_i  = 12'h008;
        addr1_i  = 12'h00C;
        wdata0_i = 32'h0000_000A;
        wdata1_i = 32'h0000_000B;
        PREADY   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();                               // SETUP
            chk_eq("ct_pwdata", PWDATA,       (k % 2 == 0) ? 32'hA : 32'hB);
            chk_eq("ct_pwrite", 32'(PWRITE),  32'h1);
            chk_eq("ct_paddr",  32'(PADDR),   (k % 2 == 0) ? 32'h008 : 32'h00C);
            tick();                               // ACCESS
            tick();                               // ack
            chk_eq("ct_ack", 32'(ack_o), (k % 2 == 0) ? 32'h1 : 32'h2);
            chk_eq("ct_err", 32'(err_o), 32'h0);
            if (k == 3) begin
                req_i = 2'b00;
            end
            tick();                               // idle gap
            chk_eq("ct_gap_psel", 32'(PSEL), 32'h0);
        end
        chk_eq("ct_rdata1_kept", rdata1_o, 32'hDEAD_BEEF);

        // Watchdog: requester 0 read, PREADY never rises
        req_i   = 2'b01;
        we_i    = 2'b00;
        addr0_i = 12'h010;
        PREADY  = 1'b0;
        PRDATA  = 32'hFFFF_FFFF;
        tick();                                   // cycle 1: SETUP
        for (int c = 2; c <= 6; c++) begin
            tick();                               // cycles 2..6: ACCESS
            chk_eq("to_psel", 32'(PSEL),  32'h1);
            chk_eq("to_ack",  32'(ack_o), 32'h0);
        end
        tick();                                   // cycle 7: abort ack
        chk_eq("to_abort_ack",   32'(ack_o),   32'h1);
        chk_eq("to_abort_err",   32'(err_o),   32'h1);
        chk_eq("to_abort_rdata", rdata0_o,     32'h1234_5678);
        chk_eq("to_abort_psel",  32'(PSEL),    32'h0);
        chk_eq("to_abort_pen",   32'(PENABLE), 32'h0);
        req_i  = 2'b00;
        PREADY = 1'b1;
        tick();                                   // idle
        chk_eq("to_idle_ack", 32'(ack_o), 32'h0);

        // Reset during ACCESS; last grant was 0 before the reset
        req_i   = 2'b01;
        we_i    = 2'b00;
        addr0_i = 12'h020;
        addr1_i = 12'h030;
        PREADY  = 1'b0;
        tick();                                   // cycle 1: SETUP
        tick();                                   // cycle 2: ACCESS
        chk_eq("mr_acc_pen", 32'(PENABLE), 32'h1);
        HRESET = 1'b1;
        tick();                                   // cycle 3: reset applied
        chk_eq("mr_psel",   32'(PSEL),    32'h0);
        chk_eq("mr_pen",    32'(PENABLE), 32'h0);
        chk_eq("mr_paddr",  32'(PADDR),   32'h0);
        chk_eq("mr_ack",    32'(ack_o),   32'h0);
        chk_eq("mr_rdata0", rdata0_o,     32'h0);
        chk_eq("mr_rdata1", rdata1_o,     32'h0);
        HRESET = 1'b0;
        req_i  = 2'b11;
        PREADY = 1'b1;
        tick();                                   // tie after reset: SETUP
        chk_eq("mr_tie_paddr", 32'(PADDR), 32'h020);
        chk_eq("mr_tie_ack",   32'(ack_o), 32'h0);
        tick();                                   // ACCESS
        tick();                                   // ack
        chk_eq("mr_tie_done", 32'(ack_o), 32'h1);
        req_i = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer_apb_arbiter.md
# timer_apb_arbiter

Two-port APB requester arbiter that shares the single APB timer peripheral between two on-chip requesters, for example the core data port and the debug module. Each requester issues simple req/ack register transfers. The block grants them round-robin, runs a full APB SETUP/ACCESS sequence toward the timer slave, and returns read data and error status. A wait-state watchdog aborts any transfer whose slave never raises PREADY.

## Interface
- APB_ADDR_WIDTH, 12, address width toward the timer slave and from both requesters
- APB_DATA_WIDTH, 32, data width
- TIMEOUT, 16, number of consecutive PREADY-low ACCESS cycles before abort; 0 disables the watchdog
- Reset polarity and timing (decided): one clock, HCLK; reset HRESET is synchronous and active-high.
- HCLK  in  1  clock, all state on rising edge
- HRESET  in  1  synchronous active-high reset
- req_i[1:0]  in  2  transfer request, one bit per requester n
- we_i[1:0]  in  2  1 = write, 0 = read, per requester
- addr0_i, addr1_i  in  APB_ADDR_WIDTH  register address per requester
- wdata0_i, wdata1_i  in  APB_DATA_WIDTH  write data per requester
- ack_o[1:0]  out  2  one-cycle completion pulse per requester
- err_o  out  1  error flag, valid only in a cycle where ack_o is nonzero
- rdata0_o, rdata1_o  out  APB_DATA_WIDTH  read data per requester; held until that requester's next ack
- PSEL, PENABLE, PWRITE  out  1  APB controls toward the timer
- PADDR  out  APB_ADDR_WIDTH  APB address
- PWDATA  out  APB_DATA_WIDTH  APB write data
- PRDATA  in  APB_DATA_WIDTH  APB read data
- PREADY, PSLVERR  in  1  APB ready and slave error

## Operation
- **FSM states:** IDLE, SETUP, ACCESS.
- **Registered outputs:** all outputs are registered.
- **Reset values:** every output is 0. FSM = IDLE, wait counter = 0, last_grant = 1, so requester 0 wins the first tie.
- **IDLE, no grant:** no grant is made while ack_o is nonzero, because the requester is dropping req in that cycle.
- **IDLE, grant:** otherwise, if req_i is nonzero, grant as follows:
  - single requester: grant it;
  - both requesting: grant the requester other than last_grant.
- **On grant:**
  - latch that requester's we, addr and wdata into PWRITE, PADDR and PWDATA;
  - set PSEL = 1, PENABLE = 0;
  - update last_grant;
  - go to SETUP.
- **SETUP:** set PENABLE = 1 and go to ACCESS unconditionally.
- **ACCESS, PREADY = 1:**
  - ack_o[g] = 1 next cycle; err_o = PSLVERR;
  - on a read, rdata_g = PRDATA; on a write, rdata is unchanged;
  - clear PSEL, PENABLE, PADDR, PWRITE and PWDATA to 0;
  - clear the wait counter and go to IDLE.
- **ACCESS, PREADY = 0:** increment the wait counter. When it reaches TIMEOUT (TIMEOUT ≠ 0):
  - abort: ack_o[g] = 1 and err_o = 1 next cycle;
  - rdata is unchanged;
  - clear the bus as in the PREADY = 1 case and go to IDLE.
- **Wait counter width:** $clog2(TIMEOUT+1), minimum 1 bit; it saturates and never wraps.
- **Bus stability:** PADDR, PWRITE and PWDATA are stable from SETUP through the final ACCESS cycle. They are 0 in IDLE.
- **Requester contract:** hold req and the command stable until ack.
  - Deasserting req early does not cancel a latched transfer; the ack is still issued.
- **Simultaneous events:** a request arriving on the same edge as another requester's ack is held off one cycle, then arbitrated.

## Timing
- **Latency:** req_i[n] high before edge 0 → SETUP in cycle 1, ACCESS in cycle 2.
  - With PREADY = 1 in cycle 2, ack_o[n] is high in cycle 3.
  - Minimum transfer is 4 cycles request-to-request, including the IDLE ack cycle.
- **Wait states:** each PREADY-low ACCESS cycle adds 1 cycle.
- **Abort:** occurs after exactly TIMEOUT wait cycles, so ack arrives TIMEOUT + 2 cycles after SETUP.
- **Reset mid-transfer:** HRESET sampled high at any edge returns all state to reset values in the next cycle.
  - PSEL drops with no ack issued; the requester must reissue.
- **Ack width:** ack_o is a single-cycle pulse, and at most one bit is set at a time.

## Test plan
- **Single read:** req0 read addr 0x004, slave PRDATA = 0x1234_5678, PREADY = 1.
  - PSEL in cycles 1–2, PENABLE in cycle 2, ack_o = 01 in cycle 3, rdata0_o = 0x1234_5678, err_o = 0.
- **Contention:** req0 and req1 both asserted continuously, writes 0xA and 0xB.
  - Order of grants: 0, 1, 0, 1. Each ack is 4 cycles apart.
  - PWDATA alternates 0xA / 0xB; ack_o alternates 01 / 10.
- **Wait states:** req1 read with PREADY low for 3 ACCESS cycles, then high with PSLVERR = 1.
  - ack_o = 10 in cycle 6, err_o = 1, PADDR stable throughout.
- **Timeout:** TIMEOUT = 4, PREADY held at 0.
  - Abort after 4 ACCESS wait cycles, ack with err_o = 1, rdata unchanged, PSEL = 0, FSM returns to IDLE.
- **Reset mid-transfer:** HRESET asserted in an ACCESS cycle.
  - All outputs 0 next cycle, no ack, and the next tie is granted to requester 0.
